ram_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the 256x8 data RAM. It shares the single RAM port between requester A (CPU datapath load/store) and requester B (debug/loader port) using a req/ack handshake. It drives the RAM's Address, MemWriteData, MemWrite and MemRead from registers, and returns read data captured from MemReadData. After reset it can optionally sweep the RAM to zero.

---
 rtl/ram_arbiter.sv | 111 +++++++++++
 tb/tb_ram_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer sharing one 256x8 data RAM port between
// the CPU datapath (A) and the debug/loader port (B), with optional zero-fill after reset.
module ram_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqA,
  input  logic              WeA,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [DATA_W-1:0] WDataA,
  output logic              AckA,
  output logic [DATA_W-1:0] RDataA,
  input  logic              ReqB,
  input  logic              WeB,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] WDataB,
  output logic              AckB,
  output logic [DATA_W-1:0] RDataB,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemReadData,
  output logic              Busy
);

  typedef enum logic [2:0] {CLEAR, IDLE, ACCESS, RWAIT, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t state;
  logic   lastB;
  logic   gntB;

  // The sweep uses Address itself as the word counter.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= CLEAR_ON_RESET ? CLEAR : IDLE;
      Busy         <= CLEAR_ON_RESET;
      lastB        <= 1'b1;
      gntB         <= 1'b0;
      AckA         <= 1'b0;
      AckB         <= 1'b0;
      RDataA       <= '0;
      RDataB       <= '0;
      Address      <= '0;
      MemWriteData <= '0;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (MemWrite && Address == LAST_ADDR) begin
            MemWrite <= 1'b0;
            Busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            Address      <= MemWrite ? Address + 1'b1 : '0;
            MemWriteData <= '0;
            MemWrite     <= 1'b1;
          end
        end
        IDLE: begin
          AckA     <= 1'b0;
          AckB     <= 1'b0;
          MemWrite <= 1'b0;
          MemRead  <= 1'b0;
          // lastB=1 means B won last, so A takes a tie.
          if (ReqA && (!ReqB || lastB)) begin
            gntB         <= 1'b0;
            lastB        <= 1'b0;
            Address      <= AddrA;
            MemWriteData <= WDataA;
            MemWrite     <= WeA;
            MemRead      <= !WeA;
            state        <= ACCESS;
          end else if (ReqB) begin
            gntB         <= 1'b1;
            lastB        <= 1'b1;
            Address      <= AddrB;
            MemWriteData <= WDataB;
            MemWrite     <= WeB;
            MemRead      <= !WeB;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          MemWrite <= 1'b0;
          MemRead  <= 1'b0;
          state    <= MemRead ? RWAIT : DONE;
        end
        RWAIT: begin
          if (gntB) RDataB <= MemReadData;
          else      RDataA <= MemReadData;
          state <= DONE;
        end
        DONE: begin
          if (gntB) AckB <= 1'b1;
          else      AckA <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: two instances (with and without the
// reset sweep), behavioural RAMs, and a reference memory/arbitration model.
module tb_ram_arbiter;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       ReqA = 1'b0, WeA = 1'b0, ReqB = 1'b0, WeB = 1'b0;
  logic [7:0] AddrA = '0, WDataA = '0, AddrB = '0, WDataB = '0;

  logic       AckA, AckB, MemWrite, MemRead, Busy;
  logic [7:0] RDataA, RDataB, Address, MemWriteData, MemReadData;
  logic       AckA0, AckB0, MemWrite0, MemRead0, Busy0;
  logic [7:0] RDataA0, RDataB0, Address0, MemWriteData0, MemReadData0;

  logic [7:0] ram [256];
  logic [7:0] ram0 [256];

  // Reference model state
  logic [7:0] refMem [256];
  logic [7:0] expRDataA = '0, expRDataB = '0;
  bit         lastB = 1'b1;

  int checks = 0, failures = 0;
  int bothCmd = 0, bothAck = 0, wrCount = 0;
  logic [7:0] lastWrAddr = '0;

  always #5 Clock = ~Clock;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .CLEAR_ON_RESET(1'b1)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqA(ReqA), .WeA(WeA), .AddrA(AddrA), .WDataA(WDataA), .AckA(AckA), .RDataA(RDataA),
    .ReqB(ReqB), .WeB(WeB), .AddrB(AddrB), .WDataB(WDataB), .AckB(AckB), .RDataB(RDataB),
    .Address(Address), .MemWriteData(MemWriteData), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemReadData(MemReadData), .Busy(Busy)
  );

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .CLEAR_ON_RESET(1'b0)) dut0 (
    .Clock(Clock), .Reset(Reset),
    .ReqA(ReqA), .WeA(WeA), .AddrA(AddrA), .WDataA(WDataA), .AckA(AckA0), .RDataA(RDataA0),
    .ReqB(ReqB), .WeB(WeB), .AddrB(AddrB), .WDataB(WDataB), .AckB(AckB0), .RDataB(RDataB0),
    .Address(Address0), .MemWriteData(MemWriteData0), .MemWrite(MemWrite0), .MemRead(MemRead0),
    .MemReadData(MemReadData0), .Busy(Busy0)
  );

  // Synchronous RAMs with registered read data; start with garbage contents.
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 8'($urandom);
      ram0[i]   = 8'($urandom);
      refMem[i] = 8'h00;
    end
  end

  always @(posedge Clock) begin
    if (MemWrite) ram[Address] <= MemWriteData;
    if (MemRead)  MemReadData  <= ram[Address];
    if (MemWrite0) ram0[Address0] <= MemWriteData0;
    if (MemRead0)  MemReadData0   <= ram0[Address0];
  end

  always @(negedge Clock) begin
    if (MemWrite && MemRead) bothCmd++;
    if (AckA && AckB) bothAck++;
    if (MemWrite && !Busy) begin
      wrCount++;
      lastWrAddr = Address;
    end
  end

  task automatic runTxn(input bit port, input bit we, input logic [7:0] addr,
                        input logic [7:0] data, output int lat, output logic [7:0] rd,
                        output bit ok);
    @(negedge Clock);
    if (port) begin ReqB = 1'b1; WeB = we; AddrB = addr; WDataB = data; end
    else      begin ReqA = 1'b1; WeA = we; AddrA = addr; WDataA = data; end
    lat = -1; rd = '0; ok = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clock);
      if ((port ? AckB : AckA) === 1'b1) begin
        lat = i - 1;
        rd  = port ? RDataB : RDataA;
        ok  = 1'b1;
        break;
      end
    end
    ReqA = 1'b0;
    ReqB = 1'b0;
  endtask

  task automatic waitSweep(output int writes, output int seqErr, output bit timedOut,
                           output bit ackSeen);
    writes = 0; seqErr = 0; timedOut = 1'b1; ackSeen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clock);
      if (Busy !== 1'b1) begin
        timedOut = 1'b0;
        break;
      end
      if (MemWrite === 1'b1) begin
        if (Address !== writes[7:0] || MemWriteData !== 8'h00) seqErr++;
        writes++;
      end
      if (AckA === 1'b1 || AckB === 1'b1) ackSeen = 1'b1;
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
    expRDataA = '0;
    expRDataB = '0;
    lastB = 1'b1;
  endtask

  task automatic setCmd(input bit p, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (p) begin WeB = we; AddrB = a; WDataB = d; end
    else   begin WeA = we; AddrA = a; WDataA = d; end
  endtask

  task automatic test_reset();
    ReqA = 1'(($urandom)); ReqB = 1'(($urandom)); WeA = 1'($urandom); WeB = 1'($urandom);
    AddrA = 8'($urandom); AddrB = 8'($urandom); WDataA = 8'($urandom); WDataB = 8'($urandom);
    repeat (3) @(negedge Clock);
    checks++;
    if ({AckA, AckB, RDataA, RDataB, Address, MemWriteData, MemWrite, MemRead} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {AckA, AckB, RDataA, RDataB, Address, MemWriteData, MemWrite, MemRead});
    end
    checks++;
    if (Busy !== 1'b1) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 1", Busy); end
    checks++;
    if ({AckA0, AckB0, RDataA0, RDataB0, Address0, MemWriteData0, MemWrite0, MemRead0, Busy0} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs_noclear: got %h expected 0",
               {AckA0, AckB0, RDataA0, RDataB0, Address0, MemWriteData0, MemWrite0, MemRead0, Busy0});
    end
    ReqA = 0; ReqB = 0; WeA = 0; WeB = 0;
  endtask

  task automatic test_clear();
    int writes, seqErr, lat;
    bit timedOut, ackSeen, ok;
    logic [7:0] rd;
    @(negedge Clock);
    ReqA = 1'b1; WeA = 1'b0; AddrA = 8'h1A; WDataA = 8'($urandom);
    Reset = 1'b1;
    waitSweep(writes, seqErr, timedOut, ackSeen);
    modelReset();
    checks++;
    if (timedOut || writes !== 256) begin
      failures++;
      $display("[TB] FAIL clear_count: got %0d writes (timeout=%b) expected 256", writes, timedOut);
    end
    checks++;
    if (seqErr !== 0) begin failures++; $display("[TB] FAIL clear_sequence: got %0d bad words expected 0", seqErr); end
    checks++;
    if (ackSeen) begin failures++; $display("[TB] FAIL clear_early_ack: got ack during Busy expected none"); end
    ok = 1'b0; rd = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (AckA === 1'b1) begin ok = 1'b1; rd = RDataA; break; end
    end
    ReqA = 1'b0;
    lat = 0;
    lastB = 1'b0;
    expRDataA = refMem[8'h1A];
    checks++;
    if (!ok || rd !== expRDataA) begin
      failures++;
      $display("[TB] FAIL clear_readback: got %h (acked=%b) expected %h", rd, ok, expRDataA);
    end
  endtask

  task automatic test_write_read();
    int lat, wc;
    logic [7:0] rd, a, d;
    bit ok, p, we;
    wc = wrCount;
    runTxn(1'b0, 1'b1, 8'h1A, 8'h03, lat, rd, ok);
    refMem[8'h1A] = 8'h03; lastB = 1'b0;
    checks++;
    if (!ok || lat !== 2) begin failures++; $display("[TB] FAIL wr_latency: got %0d expected 2", lat); end
    checks++;
    if (wrCount - wc !== 1 || lastWrAddr !== 8'h1A) begin
      failures++;
      $display("[TB] FAIL wr_pulse: got %0d cycles at %h expected 1 at 1a", wrCount - wc, lastWrAddr);
    end
    runTxn(1'b0, 1'b0, 8'h1A, 8'h00, lat, rd, ok);
    expRDataA = refMem[8'h1A];
    checks++;
    if (!ok || lat !== 3) begin failures++; $display("[TB] FAIL rd_latency: got %0d expected 3", lat); end
    checks++;
    if (rd !== 8'h03) begin failures++; $display("[TB] FAIL rd_data: got %h expected 03", rd); end
    // Random single-requester traffic against the reference memory.
    for (int n = 0; n < 10; n++) begin
      p  = 1'($urandom);
      we = 1'($urandom);
      a  = 8'($urandom_range(0, 15));
      d  = 8'($urandom);
      runTxn(p, we, a, d, lat, rd, ok);
      lastB = p;
      checks++;
      if (!ok || lat !== (we ? 2 : 3)) begin
        failures++;
        $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, we ? 2 : 3);
      end
      if (we) refMem[a] = d;
      else begin
        if (p) expRDataB = refMem[a]; else expRDataA = refMem[a];
        checks++;
        if (rd !== refMem[a]) begin
          failures++;
          $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", n, rd, refMem[a]);
        end
      end
      checks++;
      if ((p ? RDataA : RDataB) !== (p ? expRDataA : expRDataB)) begin
        failures++;
        $display("[TB] FAIL rand_other_rdata[%0d]: got %h expected %h", n,
                 p ? RDataA : RDataB, p ? expRDataA : expRDataB);
      end
    end
  endtask

  task automatic test_round_robin();
    bit weC [2];
    logic [7:0] adC [2], daC [2];
    logic [7:0] rd;
    bit expPort, p;
    int acks, ba, bc;
    acks = 0; ba = bothAck; bc = bothCmd;
    expPort = lastB ? 1'b0 : 1'b1;
    @(negedge Clock);
    for (int k = 0; k < 2; k++) begin
      weC[k] = 1'($urandom); adC[k] = 8'($urandom_range(0, 7)); daC[k] = 8'($urandom);
      setCmd(k[0], weC[k], adC[k], daC[k]);
    end
    ReqA = 1'b1; ReqB = 1'b1;
    for (int i = 0; i < 100 && acks < 4; i++) begin
      @(negedge Clock);
      if (AckA === 1'b1 || AckB === 1'b1) begin
        p = AckB;
        checks++;
        if (p !== expPort) begin
          failures++;
          $display("[TB] FAIL rr_order[%0d]: got port %0d expected port %0d", acks, p, expPort);
        end
        if (weC[p]) refMem[adC[p]] = daC[p];
        else begin
          rd = p ? RDataB : RDataA;
          if (p) expRDataB = refMem[adC[p]]; else expRDataA = refMem[adC[p]];
          checks++;
          if (rd !== refMem[adC[p]]) begin
            failures++;
            $display("[TB] FAIL rr_rdata[%0d]: got %h expected %h", acks, rd, refMem[adC[p]]);
          end
        end
        lastB = p;
        expPort = !expPort;
        acks++;
        if (acks < 4) begin
          weC[p] = 1'($urandom); adC[p] = 8'($urandom_range(0, 7)); daC[p] = 8'($urandom);
          setCmd(p, weC[p], adC[p], daC[p]);
        end else begin
          ReqA = 1'b0; ReqB = 1'b0;
        end
      end
    end
    ReqA = 1'b0; ReqB = 1'b0;
    checks++;
    if (acks !== 4) begin failures++; $display("[TB] FAIL rr_timeout: got %0d acks expected 4", acks); end
    checks++;
    if (bothAck - ba !== 0) begin failures++; $display("[TB] FAIL rr_ack_overlap: got %0d expected 0", bothAck - ba); end
    checks++;
    if (bothCmd - bc !== 0) begin failures++; $display("[TB] FAIL rr_cmd_overlap: got %0d expected 0", bothCmd - bc); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] rd;
    bit ok;
    runTxn(1'b1, 1'b1, 8'hFF, 8'h55, lat, rd, ok);
    refMem[8'hFF] = 8'h55; lastB = 1'b1;
    checks++;
    if (!ok || lat !== 2) begin failures++; $display("[TB] FAIL b_write_latency: got %0d expected 2", lat); end
    runTxn(1'b0, 1'b0, 8'hFF, 8'h00, lat, rd, ok);
    lastB = 1'b0;
    expRDataA = refMem[8'hFF];
    checks++;
    if (!ok || rd !== 8'h55) begin failures++; $display("[TB] FAIL a_read_ff: got %h expected 55", rd); end
    checks++;
    if (RDataB !== expRDataB) begin
      failures++;
      $display("[TB] FAIL rdatab_held: got %h expected %h", RDataB, expRDataB);
    end
  endtask

  task automatic test_reset_midaccess();
    int writes, seqErr;
    bit timedOut, ackSeen;
    @(negedge Clock);
    ReqA = 1'b1; WeA = 1'b0; AddrA = 8'($urandom_range(1, 255));
    @(negedge Clock);
    checks++;
    if (MemRead !== 1'b1) begin failures++; $display("[TB] FAIL abort_in_access: got MemRead=%b expected 1", MemRead); end
    #2 Reset = 1'b0;
    #1;
    checks++;
    if ({MemWrite, MemRead, AckA, AckB, Address, MemWriteData} !== '0 || Busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_async: got %h busy=%b expected 0 busy=1",
               {MemWrite, MemRead, AckA, AckB, Address, MemWriteData}, Busy);
    end
    ReqA = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    waitSweep(writes, seqErr, timedOut, ackSeen);
    modelReset();
    checks++;
    if (timedOut || writes !== 256 || seqErr !== 0) begin
      failures++;
      $display("[TB] FAIL abort_resweep: got %0d writes %0d bad (timeout=%b) expected 256 0",
               writes, seqErr, timedOut);
    end
    checks++;
    if (ackSeen || RDataA !== expRDataA) begin
      failures++;
      $display("[TB] FAIL abort_no_ack: got ack=%b rdata=%h expected ack=0 rdata=%h", ackSeen, RDataA, expRDataA);
    end
  endtask

  task automatic test_no_clear();
    int lat, writes, seqErr;
    bit busySeen, ackMain, timedOut, ackSeen;
    logic [7:0] a, d;
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    checks++;
    if (Busy0 !== 1'b0) begin failures++; $display("[TB] FAIL noclear_reset_busy: got %b expected 0", Busy0); end
    @(negedge Clock);
    a = 8'($urandom); d = 8'($urandom);
    Reset = 1'b1;
    ReqA = 1'b1; WeA = 1'b1; AddrA = a; WDataA = d;
    lat = -1; busySeen = 1'b0; ackMain = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clock);
      if (Busy0 === 1'b1) busySeen = 1'b1;
      if (AckA === 1'b1) ackMain = 1'b1;
      if (AckA0 === 1'b1) begin lat = i - 1; break; end
    end
    ReqA = 1'b0;
    checks++;
    if (lat !== 2) begin failures++; $display("[TB] FAIL noclear_latency: got %0d expected 2", lat); end
    checks++;
    if (busySeen || ackMain) begin
      failures++;
      $display("[TB] FAIL noclear_busy: got busy0=%b clearing-ack=%b expected 0 0", busySeen, ackMain);
    end
    checks++;
    if (ram0[a] !== d) begin failures++; $display("[TB] FAIL noclear_write: got %h expected %h", ram0[a], d); end
    waitSweep(writes, seqErr, timedOut, ackSeen);
    modelReset();
    checks++;
    if (timedOut || ackSeen || writes < 250) begin
      failures++;
      $display("[TB] FAIL noclear_main_sweep: got %0d writes ack=%b timeout=%b expected sweep without ack",
               writes, ackSeen, timedOut);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_reset_midaccess();
    test_no_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
